// File: rtl/counter_pkg.sv
// Shared types and helpers for the synchronous up counter.
//   state_e    : counter mode, RUN (counting/wrapping) or SAT (parked at terminal)
//   clamp_load : limits a parallel-load value to the terminal count
package counter_pkg;

    typedef enum logic {
        RUN = 1'b0,
        SAT = 1'b1
    } state_e;

    // Values are widened to 32 bits so one helper serves every counter width.
    function automatic int unsigned clamp_load(input int unsigned val,
                                               input int unsigned max_count);
        return (val > max_count) ? max_count : val;
    endfunction

endpackage

// File: rtl/sync_up_counter_if.sv
// Control and status bundle of the synchronous up counter.
//   en, clear, load, load_val, sat_mode : controls driven by the user (master)
//   count, tc, wrap, done, ovf          : status driven by the counter (slave)
interface sync_up_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             clear;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             sat_mode;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             wrap;
    logic             done;
    logic             ovf;

    modport master (
        output en, clear, load, load_val, sat_mode,
        input  count, tc, wrap, done, ovf
    );

    modport slave (
        input  en, clear, load, load_val, sat_mode,
        output count, tc, wrap, done, ovf
    );
endinterface

// File: rtl/sync_up_counter.sv
// Synchronous up counter with enable, parallel load, synchronous clear and
// wrap/saturate selection at a programmable terminal value MAX_COUNT.
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous active-low reset
//   bus    : sync_up_counter_if slave modport
//            en/clear/load/load_val/sat_mode in (priority clear > load > en)
//            count  registered count
//            tc     count == MAX_COUNT (decoded from the count register)
//            wrap   one-cycle pulse on each wrap to 0
//            done   high while parked in SAT
//            ovf    sticky overflow, cleared only by clear or reset
module sync_up_counter
    import counter_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MAX_COUNT = 15
) (
    input  logic              clk,
    input  logic              reset,
    sync_up_counter_if.slave  bus
);

    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_COUNT);

    state_e           state_reg, state_next;
    logic [WIDTH-1:0] count_reg, count_next;
    logic             wrap_reg,  wrap_next;
    logic             ovf_reg,   ovf_next;
    logic [WIDTH-1:0] load_clamped;

    assign load_clamped = WIDTH'(clamp_load(32'(bus.load_val), 32'(MAX_COUNT)));

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        wrap_next  = 1'b0;
        ovf_next   = ovf_reg;

        if (bus.clear) begin
            state_next = RUN;
            count_next = '0;
            ovf_next   = 1'b0;
        end else if (bus.load) begin
            count_next = load_clamped;
            state_next = (load_clamped == MAX_C && bus.sat_mode) ? SAT : RUN;
        end else if (bus.en) begin
            unique case (state_reg)
                RUN: begin
                    if (count_reg < MAX_C) begin
                        count_next = count_reg + WIDTH'(1);
                        // Arriving at the terminal value parks immediately;
                        // overflow is only flagged by a further enabled edge.
                        if (count_reg + WIDTH'(1) == MAX_C && bus.sat_mode)
                            state_next = SAT;
                    end else begin
                        ovf_next = 1'b1;
                        if (bus.sat_mode) begin
                            state_next = SAT;
                        end else begin
                            count_next = '0;
                            wrap_next  = 1'b1;
                        end
                    end
                end
                SAT: begin
                    // Every enabled edge at the terminal value is an overflow.
                    // With saturation switched off the counter wraps out of SAT.
                    ovf_next = 1'b1;
                    if (!bus.sat_mode) begin
                        count_next = '0;
                        wrap_next  = 1'b1;
                        state_next = RUN;
                    end
                end
                default: state_next = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= RUN;
            count_reg <= '0;
            wrap_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            wrap_reg  <= wrap_next;
            ovf_reg   <= ovf_next;
        end
    end

    assign bus.count = count_reg;
    assign bus.tc    = (count_reg == MAX_C);
    assign bus.wrap  = wrap_reg;
    assign bus.done  = (state_reg == SAT);
    assign bus.ovf   = ovf_reg;

endmodule

// File: tb/tb_sync_up_counter.sv
// Bench for sync_up_counter: three instances (MAX_COUNT 15, 9, 1) checked on
// every falling edge against a behavioural model, plus directed literal checks.
module tb_sync_up_counter;
    import counter_pkg::*;

    localparam int N = 3;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int maxv [N] = '{15, 9, 1};

    logic       en   [N];
    logic       clr  [N];
    logic       ld   [N];
    logic       sat  [N];
    logic [3:0] lv   [N];
    logic [3:0] cnt  [N];
    logic       tcs  [N];
    logic       wrs  [N];
    logic       dns  [N];
    logic       ovs  [N];

    sync_up_counter_if #(.WIDTH(4)) ifs [N] ();

    for (genvar gi = 0; gi < N; gi++) begin : g_dut
        localparam int MAXV = (gi == 0) ? 15 : (gi == 1) ? 9 : 1;
        assign ifs[gi].en       = en[gi];
        assign ifs[gi].clear    = clr[gi];
        assign ifs[gi].load     = ld[gi];
        assign ifs[gi].load_val = lv[gi];
        assign ifs[gi].sat_mode = sat[gi];
        assign cnt[gi] = ifs[gi].count;
        assign tcs[gi] = ifs[gi].tc;
        assign wrs[gi] = ifs[gi].wrap;
        assign dns[gi] = ifs[gi].done;
        assign ovs[gi] = ifs[gi].ovf;

        sync_up_counter #(.WIDTH(4), .MAX_COUNT(MAXV)) dut (
            .clk   (clk),
            .reset (reset),
            .bus   (ifs[gi])
        );
    end

    int vectors = 0;
    int fails   = 0;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: value, parked flag, sticky overflow, wrap pulse.
    int m_cnt [N] = '{0, 0, 0};
    bit m_park[N] = '{0, 0, 0};
    bit m_ovf [N] = '{0, 0, 0};
    bit m_wrap[N] = '{0, 0, 0};

    always @(posedge clk or negedge reset) begin
        for (int i = 0; i < N; i++) begin
            if (!reset) begin
                m_cnt[i] = 0; m_park[i] = 0; m_ovf[i] = 0; m_wrap[i] = 0;
            end else begin
                m_wrap[i] = 0;
                if (clr[i]) begin
                    m_cnt[i] = 0; m_park[i] = 0; m_ovf[i] = 0;
                end else if (ld[i]) begin
                    m_cnt[i]  = (int'(lv[i]) > maxv[i]) ? maxv[i] : int'(lv[i]);
                    m_park[i] = (m_cnt[i] == maxv[i]) && sat[i];
                end else if (en[i]) begin
                    if (m_cnt[i] < maxv[i]) begin
                        m_cnt[i]++;
                        if (m_cnt[i] == maxv[i] && sat[i]) m_park[i] = 1;
                    end else begin
                        m_ovf[i] = 1;
                        if (sat[i]) m_park[i] = 1;
                        else begin
                            m_cnt[i] = 0; m_wrap[i] = 1; m_park[i] = 0;
                        end
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            check($sformatf("dut%0d count", i), int'(cnt[i]), m_cnt[i]);
            check($sformatf("dut%0d tc", i),    int'(tcs[i]), int'(m_cnt[i] == maxv[i]));
            check($sformatf("dut%0d wrap", i),  int'(wrs[i]), int'(m_wrap[i]));
            check($sformatf("dut%0d done", i),  int'(dns[i]), int'(m_park[i]));
            check($sformatf("dut%0d ovf", i),   int'(ovs[i]), int'(m_ovf[i]));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            en[i] = 0; clr[i] = 0; ld[i] = 0; sat[i] = 0; lv[i] = '0;
        end
        #1 reset = 1'b0;
        step(); step();
        check("reset count", int'(cnt[0]), 0);
        check("reset tc",    int'(tcs[0]), 0);
        check("reset flags", int'({wrs[0], dns[0], ovs[0]}), 0);
        reset = 1'b1;
        step();
        check("post-release idle count", int'(cnt[0]), 0);

        // Free-running wrap mode, MAX_COUNT 15
        en[0] = 1;
        for (int k = 1; k <= 20; k++) begin
            step();
            check($sformatf("run count k=%0d", k), int'(cnt[0]), k % 16);
            if (k == 15) check("tc at 15", int'(tcs[0]), 1);
            if (k == 16) check("wrap after 15", int'(wrs[0]), 1);
            if (k == 17) check("wrap one cycle", int'(wrs[0]), 0);
        end
        check("ovf after wrap", int'(ovs[0]), 1);
        en[0] = 0; clr[0] = 1;
        step();
        clr[0] = 0;
        check("clear count", int'(cnt[0]), 0);
        check("clear ovf",   int'(ovs[0]), 0);

        // Saturate mode
        sat[0] = 1; en[0] = 1;
        for (int k = 1; k <= 15; k++) step();
        check("sat count 15", int'(cnt[0]), 15);
        check("sat done on arrival", int'(dns[0]), 1);
        check("sat ovf not yet", int'(ovs[0]), 0);
        step();
        check("sat hold", int'(cnt[0]), 15);
        check("sat ovf set", int'(ovs[0]), 1);
        check("sat no wrap", int'(wrs[0]), 0);
        sat[0] = 0;
        step();
        check("leave sat count", int'(cnt[0]), 0);
        check("leave sat wrap", int'(wrs[0]), 1);
        check("leave sat done", int'(dns[0]), 0);
        en[0] = 0;

        // Load clamping on MAX_COUNT 9
        ld[1] = 1; lv[1] = 4'd12;
        step();
        ld[1] = 0;
        check("clamp load count", int'(cnt[1]), 9);
        check("clamp load tc", int'(tcs[1]), 1);
        en[1] = 1;
        step();
        en[1] = 0;
        check("mod9 wrap count", int'(cnt[1]), 0);
        check("mod9 wrap pulse", int'(wrs[1]), 1);

        // Priority clear > load > en
        ld[0] = 1; lv[0] = 4'd5;
        step();
        check("load 5", int'(cnt[0]), 5);
        check("load keeps ovf", int'(ovs[0]), 1);
        clr[0] = 1; en[0] = 1; lv[0] = 4'd3;
        step();
        clr[0] = 0;
        check("clear wins count", int'(cnt[0]), 0);
        check("clear wins ovf", int'(ovs[0]), 0);
        lv[0] = 4'd7;
        step();
        check("load beats en", int'(cnt[0]), 7);
        en[0] = 0; lv[0] = 4'd15;
        step();
        check("load 15 tc", int'(tcs[0]), 1);
        en[0] = 1; lv[0] = 4'd2;
        step();
        ld[0] = 0;
        check("load at wrap count", int'(cnt[0]), 2);
        check("load at wrap no wrap", int'(wrs[0]), 0);
        check("load at wrap no ovf", int'(ovs[0]), 0);

        // Asynchronous reset mid-count
        for (int k = 0; k < 4; k++) step();
        check("pre-reset count", int'(cnt[0]), 6);
        #1 reset = 1'b0;
        #1;
        check("async reset count", int'(cnt[0]), 0);
        check("async reset flags", int'({tcs[0], wrs[0], dns[0], ovs[0]}), 0);
        en[0] = 0;
        step();
        reset = 1'b1;
        step();
        check("after reset count", int'(cnt[0]), 0);

        // MAX_COUNT 1: back-to-back wraps
        en[2] = 1;
        for (int k = 1; k <= 6; k++) begin
            step();
            check($sformatf("mod2 count k=%0d", k), int'(cnt[2]), k % 2);
            check($sformatf("mod2 wrap k=%0d", k), int'(wrs[2]), int'(k % 2 == 0));
        end
        en[2] = 0;

        step(); step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
